shift_seq_ctrl: RTL and testbench

Command sequencer directly upstream of the 4-bit universal shift register. It accepts one command at a time over a valid/ready handshake, decodes it, and drives the register's mode selects (`s1`, `s0`), parallel input (`inp`) and serial fill bits (`x`, `y`) for the right number of clock cycles. When the command completes it issues a one-cycle `done` pulse. It also reads back the register outputs `q` so that rotate operations can be supported.

---
 rtl/shift_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 4-bit universal shift register: drives s1/s0, inp, x and y for one command at a time.
// Optional rotate support is built when SHIFT_ROTATE_EN is defined; without it q and cmd_rot are ignored.
module shift_seq_ctrl #(
  parameter int W     = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [W-1:0]     cmd_data,
  input  logic             cmd_fill,
  input  logic             cmd_rot,
  input  logic [W-1:0]     q,
  output logic             s1,
  output logic             s0,
  output logic [W-1:0]     inp,
  output logic             x,
  output logic             y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_WAIT = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic       fill;
  } cmd_t;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [W-1:0]     inp_q, inp_d;
  logic             fill_q, fill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign cmd_ready = (state_q == IDLE);

  // Outputs are registered: the comb block computes what they must be in the
  // cycle after the edge, alongside the next state.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    mode_d  = 2'b00;
    inp_d   = inp_q;
    fill_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.op   = cmd_op;
          cmd_d.fill = cmd_fill;
          if (cmd_op == OP_LOAD) begin
            state_d = LOAD;
            mode_d  = 2'b11;
            inp_d   = cmd_data;
          end else if (cmd_cnt == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
            cnt_d   = cmd_cnt;
            mode_d  = cmd_op;
            fill_d  = (cmd_op != OP_WAIT) ? cmd_fill : 1'b0;
          end
        end
      end
      LOAD: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      SHIFT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          mode_d = cmd_q.op;
          fill_d = (cmd_q.op != OP_WAIT) ? cmd_q.fill : 1'b0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      inp_q   <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      inp_q   <= inp_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s1   = mode_q[1];
  assign s0   = mode_q[0];
  assign inp  = inp_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SHIFT_ROTATE_EN
  logic rot_q;
  logic unused_q;

  always_ff @(posedge clk) begin
    if (rst)                        rot_q <= 1'b0;
    else if (cmd_valid && cmd_ready) rot_q <= cmd_rot;
  end

  // Serial inputs close the loop through q so each update moves the end bit
  // round to the other end.
  assign x = (state_q == SHIFT && cmd_q.op == OP_SHL && rot_q) ? q[W-1] : fill_q;
  assign y = (state_q == SHIFT && cmd_q.op == OP_SHR && rot_q) ? q[0]   : fill_q;
  assign unused_q = ^q;
`else
  logic unused_cfg;

  assign x = fill_q;
  assign y = fill_q;
  assign unused_cfg = ^{q, cmd_rot};
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 4-bit universal shift register closing the q loop.
module tb_shift_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [2:0] cmd_cnt = 3'd0;
  logic [3:0] cmd_data = 4'd0;
  logic       cmd_fill = 1'b0;
  logic       cmd_rot = 1'b0;
  logic [3:0] q = 4'd0;
  logic       s1, s0, x, y, busy, done;
  logic [3:0] inp;

  int checks = 0;
  int errors = 0;

  shift_seq_ctrl #(.W(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .cmd_rot(cmd_rot), .q(q), .s1(s1), .s0(s0), .inp(inp), .x(x), .y(y),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Universal shift register: 01 toward bit0 (y into bit3), 10 toward bit3 (x into bit0), 11 load.
  always @(posedge clk) begin
    case ({s1, s0})
      2'b01: q <= {y, q[3:1]};
      2'b10: q <= {q[2:0], x};
      2'b11: q <= inp;
      default: q <= q;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command for exactly one edge; returns in the cycle after acceptance.
  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                       input logic fill, input logic rot);
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_fill = fill; cmd_rot = rot;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Issues a command and waits (bounded) until it completes and the controller is idle again.
  task automatic run(input string tag, input logic [1:0] op, input logic [2:0] cnt,
                     input logic [3:0] data, input logic fill, input logic rot);
    bit seen = 0;
    issue(op, cnt, data, fill, rot);
    for (int i = 0; i < 12 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    check({tag, "_done_seen"}, 8'(seen), 8'd1);
    tick();
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_mode",  {6'd0, s1, s0}, 8'h00);
    check("rst_inp",   8'(inp), 8'h00);
    check("rst_xy",    {6'd0, x, y}, 8'h00);
    check("rst_busy",  8'(busy), 8'd0);
    check("rst_done",  8'(done), 8'd0);
    check("rst_ready", 8'(cmd_ready), 8'd1);

    // LOAD 1011
    issue(2'b11, 3'd0, 4'b1011, 1'b0, 1'b0);
    check("ld_mode",  {6'd0, s1, s0}, 8'h03);
    check("ld_inp",   8'(inp), 8'h0b);
    check("ld_busy",  8'(busy), 8'd1);
    check("ld_ready", 8'(cmd_ready), 8'd0);
    check("ld_done0", 8'(done), 8'd0);
    tick();
    check("ld_done",  8'(done), 8'd1);
    check("ld_mode2", {6'd0, s1, s0}, 8'h00);
    check("ld_q",     8'(q), 8'h0b);
    tick();
    check("ld_idle_done",  8'(done), 8'd0);
    check("ld_idle_ready", 8'(cmd_ready), 8'd1);
    check("ld_inp_hold",   8'(inp), 8'h0b);

    // SHR cnt=2 fill=0 from 1011
    issue(2'b01, 3'd2, 4'h0, 1'b0, 1'b0);
    check("shr_m1", {6'd0, s1, s0}, 8'h01);
    check("shr_xy", {6'd0, x, y}, 8'h00);
    tick();
    check("shr_m2", {6'd0, s1, s0}, 8'h01);
    check("shr_d2", 8'(done), 8'd0);
    tick();
    check("shr_done", 8'(done), 8'd1);
    check("shr_m3",   {6'd0, s1, s0}, 8'h00);
    check("shr_q",    8'(q), 8'h02);
    tick();
    check("shr_ready", 8'(cmd_ready), 8'd1);

    // SHL cnt=3 fill=1 from 0000
    run("ld0", 2'b11, 3'd0, 4'b0000, 1'b0, 1'b0);
    issue(2'b10, 3'd3, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("shl_mode",  {6'd0, s1, s0}, 8'h02);
      check("shl_xy",    {6'd0, x, y}, 8'h03);
      check("shl_busy",  8'(busy), 8'd1);
      check("shl_ready", 8'(cmd_ready), 8'd0);
      tick();
    end
    check("shl_done",  8'(done), 8'd1);
    check("shl_busy4", 8'(busy), 8'd1);
    check("shl_ready4", 8'(cmd_ready), 8'd0);
    check("shl_xy_end", {6'd0, x, y}, 8'h00);
    check("shl_q",     8'(q), 8'h07);
    tick();
    check("shl_busy_off", 8'(busy), 8'd0);
    check("shl_ready_on", 8'(cmd_ready), 8'd1);

    // SHL cnt=0: done in the first cycle, no mode
    issue(2'b10, 3'd0, 4'h0, 1'b1, 1'b0);
    check("shl0_done", 8'(done), 8'd1);
    check("shl0_mode", {6'd0, s1, s0}, 8'h00);
    tick();
    check("shl0_q",    8'(q), 8'h07);
    check("shl0_idle", 8'(cmd_ready), 8'd1);

    // WAIT cnt=5, with a LOAD offered while busy that must be ignored
    issue(2'b00, 3'd5, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("wait_mode", {6'd0, s1, s0}, 8'h00);
      check("wait_done", 8'(done), 8'd0);
      check("wait_busy", 8'(busy), 8'd1);
      if (i == 1) begin
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1111;
      end
      if (i == 3) cmd_valid = 1'b0;
      tick();
    end
    check("wait_done6", 8'(done), 8'd1);
    check("wait_q",     8'(q), 8'h07);
    check("wait_inp",   8'(inp), 8'h00);
    tick();
    check("wait_idle_mode", {6'd0, s1, s0}, 8'h00);

`ifdef SHIFT_ROTATE_EN
    run("ld8", 2'b11, 3'd0, 4'b1000, 1'b0, 1'b0);
    issue(2'b10, 3'd1, 4'h0, 1'b0, 1'b1);
    check("rol_x", 8'(x), 8'd1);
    tick();
    check("rol_q", 8'(q), 8'h01);
    tick();
    run("ror", 2'b01, 3'd4, 4'h0, 1'b0, 1'b1);
    check("ror_q", 8'(q), 8'h01);
`endif

    // Reset in the second cycle of SHR cnt=5 from 1100
    run("ldc", 2'b11, 3'd0, 4'b1100, 1'b0, 1'b0);
    issue(2'b01, 3'd5, 4'h0, 1'b1, 1'b0);
    check("rm_m1", {6'd0, s1, s0}, 8'h01);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm_mode",  {6'd0, s1, s0}, 8'h00);
    check("rm_xy",    {6'd0, x, y}, 8'h00);
    check("rm_inp",   8'(inp), 8'h00);
    check("rm_busy",  8'(busy), 8'd0);
    check("rm_done",  8'(done), 8'd0);
    check("rm_ready", 8'(cmd_ready), 8'd1);
    check("rm_q",     8'(q), 8'h0f);
    tick();
    check("rm_done2", 8'(done), 8'd0);
    check("rm_q2",    8'(q), 8'h0f);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
